// File: rtl/constants.sv
// Project-wide constants shared by the datapath blocks.
// The 16-way demultiplexer takes its word width, way count and popcount helper from here.
package constants;

    localparam int WORD_LENGTH      = 16;
    localparam int DEMUX16_WAYS     = 16;
    localparam int DEMUX16_SEL_BITS = 4;

    // Number of set bits in a 16-bit vector; the result fits 0..16.
    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            acc = acc + 5'(v[i]);
        end
        return acc;
    endfunction

endpackage

// File: rtl/_demux_slot.sv
// One-word holding slot with an EMPTY/FULL state, where the valid bit is the state.
// A load wins over a drain, so a drain and a reload in the same cycle leave the slot FULL with the new word.
module _demux_slot #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         drain,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid
);

    logic [W-1:0] r_q;
    logic         r_valid;

    // NOTE: state registers use non-blocking assignments so that every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_q     <= '0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_q     <= d;
        end else if (drain) begin
            r_valid <= 1'b0;
        end
    end

    assign q     = r_q;
    assign valid = r_valid;

endmodule

// File: rtl/_demux16_buf.sv
// Buffered 1-to-16 demultiplexer: each word is routed to its destination's one-word slot.
// Each slot has its own valid/ready pair, so a stalled consumer blocks only its own slot.
module _demux16_buf
    import constants::*;
#(
    parameter int n = constants::WORD_LENGTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DEMUX16_SEL_BITS-1:0] sel,
    input  logic [n-1:0]                in,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [n-1:0]                out [DEMUX16_WAYS-1:0],
    output logic [DEMUX16_WAYS-1:0]     out_valid,
    input  logic [DEMUX16_WAYS-1:0]     out_ready,
    output logic [4:0]                  count
);

    logic [DEMUX16_WAYS-1:0] w_valid;
    logic [DEMUX16_WAYS-1:0] w_drain;
    logic [DEMUX16_WAYS-1:0] w_load;
    logic                    w_fire_in;
    logic [4:0]              w_count_next;
    logic [4:0]              r_count;

    // A FULL slot can still accept when its consumer drains in the same cycle.
    assign in_ready  = ~reset & (~w_valid[sel] | out_ready[sel]);
    assign w_fire_in = in_valid & in_ready;
    assign w_drain   = w_valid & out_ready;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_load = '0;
        if (w_fire_in) begin
            w_load[sel] = 1'b1;
        end
    end

    for (genvar g = 0; g < DEMUX16_WAYS; g++) begin : g_slot
        _demux_slot #(.W(n)) u_slot (
            .clk   (clk),
            .reset (reset),
            .load  (w_load[g]),
            .drain (w_drain[g]),
            .d     (in),
            .q     (out[g]),
            .valid (w_valid[g])
        );
    end

    assign w_count_next = r_count + 5'(w_fire_in) - popcount16(w_drain);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign out_valid = w_valid;
    assign count     = r_count;

endmodule

// File: tb/tb__demux16_buf.sv
// Directed self-checking bench for _demux16_buf at n=16.
// Inputs change and outputs are sampled on the falling edge; state advances on the rising edge.
module tb__demux16_buf;

    logic        clk;
    logic        reset;
    logic [3:0]  sel;
    logic [15:0] in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out [15:0];
    logic [15:0] out_valid;
    logic [15:0] out_ready;
    logic [4:0]  count;

    int checks;
    int errors;

    _demux16_buf #(.n(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .sel       (sel),
        .in        (in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 16'h0000) begin
            errors++;
            $display("FAIL reset_out_valid: got %h expected %h", out_valid, 16'h0000);
        end
        checks++;
        if (count !== 5'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected %0d", count, 0);
        end
        checks++;
        if (out[9] !== 16'h0000) begin
            errors++;
            $display("FAIL reset_out9: got %h expected %h", out[9], 16'h0000);
        end
        for (int i = 0; i < 16; i++) begin
            sel = 4'(i);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_in_ready sel=%0d: got %b expected 1", i, in_ready);
            end
        end
    endtask

    task automatic test_fill();
        out_ready = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            sel      = 4'(i);
            in       = 16'hA000 + 16'(i);
            in_valid = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL fill_accept sel=%0d: got in_ready %b expected 1", i, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 16'hFFFF) begin
            errors++;
            $display("FAIL fill_out_valid: got %h expected %h", out_valid, 16'hFFFF);
        end
        checks++;
        if (count !== 5'd16) begin
            errors++;
            $display("FAIL fill_count: got %0d expected %0d", count, 16);
        end
        checks++;
        if (out[5] !== 16'hA005) begin
            errors++;
            $display("FAIL fill_out5: got %h expected %h", out[5], 16'hA005);
        end
        checks++;
        if (out[15] !== 16'hA00F) begin
            errors++;
            $display("FAIL fill_out15: got %h expected %h", out[15], 16'hA00F);
        end
        for (int i = 0; i < 16; i++) begin
            sel = 4'(i);
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL full_in_ready sel=%0d: got %b expected 0", i, in_ready);
            end
        end
        // Drain everything at once: sixteen pops in one cycle.
        out_ready = 16'hFFFF;
        tick();
        out_ready = 16'h0000;
        checks++;
        if (count !== 5'd0 || out_valid !== 16'h0000) begin
            errors++;
            $display("FAIL fill_drain_all: got count %0d valid %h expected 0 0000", count, out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 16'h0000;
        sel       = 4'd3;
        in        = 16'h1111;
        in_valid  = 1'b1;
        tick();
        in = 16'h2222;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || out[3] !== 16'h1111) begin
                errors++;
                $display("FAIL bp_stall cyc=%0d: got in_ready %b out3 %h expected 0 1111", k, in_ready, out[3]);
            end
            tick();
        end
        out_ready = 16'h0008;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got in_ready %b expected 1", in_ready);
        end
        tick();
        in_valid  = 1'b0;
        out_ready = 16'h0000;
        checks++;
        if (out[3] !== 16'h2222 || out_valid !== 16'h0008) begin
            errors++;
            $display("FAIL bp_reload: got out3 %h valid %h expected 2222 0008", out[3], out_valid);
        end
        checks++;
        if (count !== 5'd1) begin
            errors++;
            $display("FAIL bp_count: got %0d expected %0d", count, 1);
        end
        out_ready = 16'h0008;
        tick();
        out_ready = 16'h0000;
        checks++;
        if (count !== 5'd0) begin
            errors++;
            $display("FAIL bp_drain_count: got %0d expected %0d", count, 0);
        end
    endtask

    task automatic test_streaming();
        int consumed;
        consumed  = 0;
        sel       = 4'd7;
        out_ready = 16'h0080;
        for (int k = 0; k < 9; k++) begin
            in_valid = (k < 8);
            in       = 16'h0100 + 16'(k);
            #1;
            if (k < 8) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_accept k=%0d: got in_ready %b expected 1", k, in_ready);
                end
            end
            if (out_valid[7]) begin
                checks++;
                if (out[7] !== 16'h0100 + 16'(consumed)) begin
                    errors++;
                    $display("FAIL stream_order n=%0d: got %h expected %h", consumed, out[7], 16'h0100 + 16'(consumed));
                end
                consumed++;
            end
            tick();
            checks++;
            if (count !== ((k < 8) ? 5'd1 : 5'd0)) begin
                errors++;
                $display("FAIL stream_count k=%0d: got %0d expected %0d", k, count, (k < 8) ? 1 : 0);
            end
        end
        in_valid  = 1'b0;
        out_ready = 16'h0000;
        checks++;
        if (consumed != 8) begin
            errors++;
            $display("FAIL stream_total: got %0d words expected 8", consumed);
        end
    endtask

    task automatic test_simultaneous();
        out_ready = 16'h0000;
        in_valid  = 1'b1;
        sel       = 4'd2;
        in        = 16'h0202;
        tick();
        sel = 4'd9;
        in  = 16'h0909;
        tick();
        sel       = 4'd12;
        in        = 16'hC0C0;
        out_ready = 16'h0204;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL simul_accept: got in_ready %b expected 1", in_ready);
        end
        tick();
        in_valid  = 1'b0;
        out_ready = 16'h0000;
        checks++;
        if (out_valid !== 16'h1000 || count !== 5'd1) begin
            errors++;
            $display("FAIL simul_state: got valid %h count %0d expected 1000 1", out_valid, count);
        end
        checks++;
        if (out[12] !== 16'hC0C0) begin
            errors++;
            $display("FAIL simul_out12: got %h expected %h", out[12], 16'hC0C0);
        end
        out_ready = 16'h1000;
        tick();
        out_ready = 16'h0000;
    endtask

    task automatic test_mid_reset();
        out_ready = 16'h0000;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sel = 4'(i);
            in  = 16'h5000 + 16'(i);
            tick();
        end
        checks++;
        if (count !== 5'd5) begin
            errors++;
            $display("FAIL mreset_pre_count: got %0d expected %0d", count, 5);
        end
        reset = 1'b1;
        sel   = 4'd6;
        in    = 16'hDEAD;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mreset_in_ready: got %b expected 0", in_ready);
        end
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 16'h0000 || count !== 5'd0) begin
            errors++;
            $display("FAIL mreset_state: got valid %h count %0d expected 0000 0", out_valid, count);
        end
        checks++;
        if (out[6] !== 16'h0000 || out[0] !== 16'h0000) begin
            errors++;
            $display("FAIL mreset_data: got out6 %h out0 %h expected 0000 0000", out[6], out[0]);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        sel       = 4'd0;
        in        = 16'h0000;
        in_valid  = 1'b0;
        out_ready = 16'h0000;
        @(negedge clk);
        test_reset();
        test_fill();
        test_backpressure();
        test_streaming();
        test_simultaneous();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
